// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the sync generator and
// the pixel/RGB stage.
//   VGA_H_* / VGA_V_*  : porch, sync and active widths (pixels / lines)
//   VGA_H_TOTAL/V_TOTAL: full line / frame lengths (800 / 525)
//   VGA_CNT_W          : default counter width (holds 799 and 524)
//   SYNC_ACTIVE_LOW/HIGH: sync polarity values for the SYNC_POL parameter
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_CNT_W = 10;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_sync_gen_rise_detect.sv
// rise_detect: one-clk pulse on each 0->1 transition of a level input.
//   clk   : system clock
//   rst   : synchronous active-high reset; history resets to 1 so an input
//           already high when reset releases does not produce a pulse
//   in    : level input
//   pulse : combinational in & ~history
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b1;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: horizontal/vertical counters, sync pulses, active-video flag
// and frame strobe for a VGA raster (defaults: 640x480@60, 25 MHz pixels on a
// 100 MHz clk).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   pix_en     : pixel enable from the clock divider
//   x, y       : current pixel / line counters
//   hsync      : SYNC_POL inside the horizontal sync window, else ~SYNC_POL
//   vsync      : SYNC_POL inside the vertical sync window, else ~SYNC_POL
//   video_on   : high while x < H_ACTIVE and y < V_ACTIVE
//   frame_tick : one-clk pulse when (x,y) becomes (0, V_ACTIVE)
// Configuration macro VGA_SYNC_EDGE_DETECT_EN:
//   defined   -> counters advance once per rising edge of pix_en
//   undefined -> counters advance on every clk with pix_en high (pix_en must
//                be a single-cycle strobe)
// Every output is a register loaded from the next x/y values, so all outputs
// move together on the same clk edge.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CNT_W    = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  // Sync windows are [start, end) in counter units.
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic tick;

`ifdef VGA_SYNC_EDGE_DETECT_EN
  rise_detect u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .in    (pix_en),
    .pulse (tick)
  );
`else
  assign tick = pix_en;
`endif

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             video_on_nxt;
  logic             frame_tick_nxt;

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (tick) begin
      if (x == H_LAST) begin
        x_nxt = '0;
        if (y == V_LAST) begin
          y_nxt = '0;
        end else begin
          y_nxt = y + 1'b1;
        end
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_nxt    = ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt    = ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_nxt = (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
    // Qualified by tick so the strobe lasts one clk even though (0,V_ACTIVE)
    // persists until the next pixel.
    frame_tick_nxt = tick && (x_nxt == '0) && (y_nxt == V_ACT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= H_LAST;
      y          <= V_LAST;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      video_on   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      video_on   <= video_on_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one instance with the default 640x480 timing and
// active-low sync, one with a tiny raster (16x12 total) and active-high sync
// so that whole frames fit in a short run. Both share clk, rst and pix_en.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst;
  logic       pix_en;

  logic [9:0] x, y;
  logic       hsync, vsync, video_on, frame_tick;

  logic [9:0] s_x, s_y;
  logic       s_hsync, s_vsync, s_video_on, s_frame_tick;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model positions: big raster (ex, ey), small raster (sx, sy).
  int ex, ey, sx, sy;

  vga_sync_gen u_dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .frame_tick (frame_tick)
  );

  // Small raster: H 8+2+3+3 = 16 (hsync window 10..12),
  //               V 6+1+2+3 = 12 (vsync window 7..8), sync active-high.
  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1), .CNT_W (10)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .x          (s_x),
    .y          (s_y),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .video_on   (s_video_on),
    .frame_tick (s_frame_tick)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    ex = 799; ey = 524; sx = 15; sy = 11;
  endtask

  task automatic advance_model();
    if (ex == 799) begin
      ex = 0;
      ey = (ey == 524) ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
    if (sx == 15) begin
      sx = 0;
      sy = (sy == 11) ? 0 : sy + 1;
    end else begin
      sx = sx + 1;
    end
  endtask

  // One low clk (clears edge history) then one high clk; returns just after
  // the edge that consumed the tick, so outputs show the new position.
  task automatic tick_once();
    pix_en = 1'b0;
    step();
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    advance_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    step();
    step();
    reset_model();
    n_cmp++; if (x !== 10'd799) begin n_fail++; $display("FAIL reset_x: got %0d want 799", x); end
    n_cmp++; if (y !== 10'd524) begin n_fail++; $display("FAIL reset_y: got %0d want 524", y); end
    n_cmp++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    n_cmp++; if (video_on !== 1'b0) begin n_fail++; $display("FAIL reset_video_on: got %b want 0", video_on); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
    n_cmp++; if (s_x !== 10'd15) begin n_fail++; $display("FAIL reset_small_x: got %0d want 15", s_x); end
    n_cmp++; if (s_y !== 10'd11) begin n_fail++; $display("FAIL reset_small_y: got %0d want 11", s_y); end
    n_cmp++; if (s_hsync !== 1'b0) begin n_fail++; $display("FAIL reset_small_hsync: got %b want 0", s_hsync); end
    n_cmp++; if (s_vsync !== 1'b0) begin n_fail++; $display("FAIL reset_small_vsync: got %b want 0", s_vsync); end
    rst = 1'b0;
    step();
    step();
    n_cmp++; if (x !== 10'd799) begin n_fail++; $display("FAIL idle_hold_x: got %0d want 799", x); end
  endtask

  task automatic test_first_tick();
    tick_once();
    n_cmp++; if (x !== 10'd0) begin n_fail++; $display("FAIL first_x: got %0d want 0", x); end
    n_cmp++; if (y !== 10'd0) begin n_fail++; $display("FAIL first_y: got %0d want 0", y); end
    n_cmp++; if (video_on !== 1'b1) begin n_fail++; $display("FAIL first_video_on: got %b want 1", video_on); end
    n_cmp++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL first_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL first_vsync: got %b want 1", vsync); end
    n_cmp++; if (s_hsync !== 1'b0) begin n_fail++; $display("FAIL first_small_hsync: got %b want 0", s_hsync); end
    n_cmp++; if (s_video_on !== 1'b1) begin n_fail++; $display("FAIL first_small_video_on: got %b want 1", s_video_on); end
    // Between ticks the position holds.
    step();
    step();
    n_cmp++; if (x !== 10'd0) begin n_fail++; $display("FAIL hold_x: got %0d want 0", x); end
  endtask

  task automatic test_full_line();
    int hs_low = 0;
    logic exp_hs, exp_vo;
    for (int i = 0; i < 800; i++) begin
      tick_once();
      exp_hs = (ex >= 656 && ex < 752) ? 1'b0 : 1'b1;
      exp_vo = (ex < 640 && ey < 480);
      if (hsync === 1'b0) hs_low++;
      n_cmp++; if (x !== 10'(ex)) begin n_fail++; $display("FAIL line_x: got %0d want %0d", x, ex); end
      n_cmp++; if (y !== 10'(ey)) begin n_fail++; $display("FAIL line_y: got %0d want %0d at x=%0d", y, ey, ex); end
      n_cmp++; if (hsync !== exp_hs) begin n_fail++; $display("FAIL line_hsync: got %b want %b at x=%0d", hsync, exp_hs, ex); end
      n_cmp++; if (video_on !== exp_vo) begin n_fail++; $display("FAIL line_video_on: got %b want %b at x=%0d", video_on, exp_vo, ex); end
    end
    n_cmp++; if (x !== 10'd0 || y !== 10'd1) begin n_fail++; $display("FAIL line_end: got (%0d,%0d) want (0,1)", x, y); end
    n_cmp++; if (hs_low != 96) begin n_fail++; $display("FAIL line_hsync_width: got %0d want 96", hs_low); end
  endtask

  task automatic test_small_frame();
    int ft_cnt = 0;
    int vs_cnt = 0;
    logic exp_hs, exp_vs, exp_vo, exp_ft;
    for (int i = 0; i < 384; i++) begin
      tick_once();
      exp_hs = (sx >= 10 && sx < 13);
      exp_vs = (sy >= 7 && sy < 9);
      exp_vo = (sx < 8 && sy < 6);
      exp_ft = (sx == 0 && sy == 6);
      if (s_frame_tick === 1'b1) ft_cnt++;
      if (s_vsync === 1'b1) vs_cnt++;
      n_cmp++; if (s_x !== 10'(sx) || s_y !== 10'(sy)) begin n_fail++; $display("FAIL small_xy: got (%0d,%0d) want (%0d,%0d)", s_x, s_y, sx, sy); end
      n_cmp++; if (s_hsync !== exp_hs) begin n_fail++; $display("FAIL small_hsync: got %b want %b at (%0d,%0d)", s_hsync, exp_hs, sx, sy); end
      n_cmp++; if (s_vsync !== exp_vs) begin n_fail++; $display("FAIL small_vsync: got %b want %b at (%0d,%0d)", s_vsync, exp_vs, sx, sy); end
      n_cmp++; if (s_video_on !== exp_vo) begin n_fail++; $display("FAIL small_video_on: got %b want %b at (%0d,%0d)", s_video_on, exp_vo, sx, sy); end
      n_cmp++; if (s_frame_tick !== exp_ft) begin n_fail++; $display("FAIL small_frame_tick: got %b want %b at (%0d,%0d)", s_frame_tick, exp_ft, sx, sy); end
      if (exp_ft) begin
        step();
        n_cmp++; if (s_frame_tick !== 1'b0) begin n_fail++; $display("FAIL small_frame_tick_width: got %b want 0", s_frame_tick); end
      end
    end
    n_cmp++; if (ft_cnt != 2) begin n_fail++; $display("FAIL small_frame_tick_count: got %0d want 2", ft_cnt); end
    n_cmp++; if (vs_cnt != 64) begin n_fail++; $display("FAIL small_vsync_ticks: got %0d want 64", vs_cnt); end
  endtask

  task automatic test_held_high();
    int n_inc;
`ifdef VGA_SYNC_EDGE_DETECT_EN
    n_inc = 1;
`else
    n_inc = 10;
`endif
    pix_en = 1'b0;
    step();
    pix_en = 1'b1;
    repeat (10) step();
    pix_en = 1'b0;
    step();
    for (int i = 0; i < n_inc; i++) advance_model();
    n_cmp++; if (x !== 10'(ex) || y !== 10'(ey)) begin n_fail++; $display("FAIL held_xy: got (%0d,%0d) want (%0d,%0d)", x, y, ex, ey); end
    n_cmp++; if (s_x !== 10'(sx) || s_y !== 10'(sy)) begin n_fail++; $display("FAIL held_small_xy: got (%0d,%0d) want (%0d,%0d)", s_x, s_y, sx, sy); end
  endtask

  task automatic test_reset_mid();
    // Reset coincident with a pix_en rise: reset wins.
    for (int i = 0; i < 5; i++) tick_once();
    pix_en = 1'b0;
    step();
    rst = 1'b1;
    pix_en = 1'b1;
    step();
    reset_model();
    n_cmp++; if (x !== 10'd799 || y !== 10'd524) begin n_fail++; $display("FAIL rst_mid_xy: got (%0d,%0d) want (799,524)", x, y); end
    n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sync: got %b%b want 11", hsync, vsync); end
    n_cmp++; if (video_on !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b%b want 00", video_on, frame_tick); end
    n_cmp++; if (s_x !== 10'd15 || s_y !== 10'd11) begin n_fail++; $display("FAIL rst_mid_small_xy: got (%0d,%0d) want (15,11)", s_x, s_y); end
    rst = 1'b0;
    pix_en = 1'b0;
    step();
    tick_once();
    n_cmp++; if (x !== 10'd0 || y !== 10'd0) begin n_fail++; $display("FAIL rst_mid_restart: got (%0d,%0d) want (0,0)", x, y); end
    // pix_en already high as reset releases.
    rst = 1'b1;
    pix_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    reset_model();
`ifndef VGA_SYNC_EDGE_DETECT_EN
    advance_model();
`endif
    n_cmp++; if (x !== 10'(ex) || y !== 10'(ey)) begin n_fail++; $display("FAIL rst_release_high: got (%0d,%0d) want (%0d,%0d)", x, y, ex, ey); end
    pix_en = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_first_tick();
    test_full_line();
    test_small_frame();
    test_held_high();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the 1-in-4 pixel enable from the clock divider (100 MHz clk, 25 MHz pixel rate).
- Generates VGA 640x480@60 horizontal/vertical counters, sync pulses, active-video flag and a frame strobe.
- Outputs feed the Game of Life cell-memory read address logic and the RGB output stage; frame_tick paces generation updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel enable from divider (level: high 2 of every 4 clk)
- x  out  CNT_W  current horizontal count
- y  out  CNT_W  current vertical count
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- frame_tick  out  1  one-clk pulse at start of vertical blank

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state in a single clk domain.
- Derived: H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525).
- tick: internal one-clk pixel strobe; its derivation is given under Optional Feature.
- On tick: x increments; if x == H_TOTAL-1, x wraps to 0 and y increments; if additionally y == V_TOTAL-1, y wraps to 0. No other condition alters x or y.
- All outputs are registered and updated in the same clk edge as x/y, computed from the next x/y values, so all outputs are always mutually consistent. No combinational path from any input to any output.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
- vsync = SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
- frame_tick = 1 for exactly one clk cycle: the cycle in which (x,y) first become (0, V_ACTIVE). Otherwise 0.
- Reset values:
  - x = H_TOTAL-1, y = V_TOTAL-1, so the first tick lands on (0,0).
  - hsync = vsync = ~SYNC_POL.
  - video_on = 0, frame_tick = 0.
  - Edge-detect history register = 1.
- Reset mid-frame: all outputs return to reset values on the next clk edge; rst takes priority over a simultaneous tick.
- Between ticks, every output holds its value.

Optional Feature:
- Macro: VGA_SYNC_EDGE_DETECT_EN.
- Defined: tick = pix_en & ~pix_en_q (registered history). Exactly one tick per 0->1 transition, regardless of how long pix_en stays high. Because history resets to 1, a pix_en already high at reset release gives no tick until a genuine rising edge.
- Undefined: tick = pix_en. Every clk cycle with pix_en high advances the counters; the upstream enable must be a single-cycle strobe. No history register is built.

Decomposition:
- Package vga_pkg holds:
  - 640x480@60 timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - the default CNT_W;
  - sync polarity localparams.
- These are shared with the pixel/RGB stage.
- One sub-module is natural: rise_detect (clk, rst, in -> pulse). It is instantiated only under VGA_SYNC_EDGE_DETECT_EN.

Test Plan:
- Reset then pix_en = 0,0,1,1 repeating (macro on) -> first tick on first rise; x=0, y=0, video_on=1, hsync=vsync=1; thereafter one increment per 4 clk.
- Full line (macro on) -> x goes 0..799 then back to 0 and y becomes 1. Line period = 3200 clk. hsync low for exactly ticks x=656..751 (96 ticks). video_on low from x=640.
- Full frame -> y wraps 524->0. vsync low only for y=490..491 (1600 ticks). frame_tick pulses exactly once per 420000 ticks, coincident with (0,480), width 1 clk.
- pix_en held high for 10 clk -> macro on: exactly 1 increment; macro off: 10 increments.
- rst asserted at x=300, y=100 with a simultaneous tick -> next edge: x=799, y=524, hsync=vsync=1, video_on=0, frame_tick=0; next rise of pix_en gives (0,0).
- SYNC_POL=1 -> hsync/vsync idle 0, high only during windows 656..751 and 490..491; reset value 0.
